mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle main control unit: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back, and drives every datapath enable and mux select. It sits directly upstream of the ALU control decoder: it supplies the 2-bit `aluop` (0 add, 1 sub, 2 decode by opcode) and receives the ALU `zero`/`sign` flags for branch resolution. Opcode comes from the instruction register.

## Interface
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `opcode`  in  6  IR[31:26], stable from ID onward
- `zero`  in  1  ALU result == 0
- `sign`  in  1  ALU result[31]
- `pc_write`  out  1  PC load enable
- `ir_write`  out  1  IR load enable
- `mem_read`, `mem_write`  out  1 each  data memory strobes
- `reg_write`  out  1  register file write enable
- `aluop`  out  2  to ALU control: 0 add, 1 sub, 2 by opcode
- `alu_src_a`  out  2  00 PC, 01 reg A (rs), 10 shamt
- `alu_src_b`  out  2  00 reg B (rt), 01 constant 4, 10 extended imm, 11 zero
- `ext_sel`  out  1  1 sign-extend, 0 zero-extend
- `pc_src`  out  2  00 ALU result, 01 branch target, 10 jump target, 11 rs
- `reg_dst`  out  2  00 rt, 01 rd, 10 $31
- `wb_src`  out  2  00 ALUOut, 01 memory data, 10 PC (return address)
- `halted`  out  1  high in HALT
- `instret`  out  32  retired count (only with CTRL_INSTRET_EN)

## Operation
- Opcodes: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, xori 010011, sll 011000, slti 100110, slt 100111, sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111; others are NOP.
- States: IF, ID, EXE_AL, WB_AL, EXE_BR, EXE_LS, MEM, WB_LD, HALT (4-bit encoding).
- IF: ir_write=1, pc_write=1, alu_src_a=00, alu_src_b=01, aluop=0, pc_src=00 -> ID.
- ID dispatch: ALU class -> EXE_AL; beq/bne/bltz -> EXE_BR; lw/sw -> EXE_LS; j: pc_write, pc_src=10 -> IF; jr: pc_write, pc_src=11 -> IF; jal: pc_write, pc_src=10, reg_write, reg_dst=10, wb_src=10 -> IF; halt -> HALT; NOP -> IF, no writes.
- EXE_AL: aluop=2; alu_src_a=10 for sll else 01; alu_src_b=00 for add/sub/and/sll/slt, 10 for immediates -> WB_AL.
- WB_AL: reg_write=1, wb_src=00, reg_dst=01 for register-form ops, 00 for immediates -> IF.
- EXE_BR: aluop=1, alu_src_a=01, alu_src_b=00 (11 for bltz); pc_src=01; pc_write = (beq&zero)|(bne&~zero)|(bltz&sign) -> IF.
- EXE_LS: aluop=0, alu_src_a=01, alu_src_b=10 -> MEM.
- MEM: lw mem_read=1 -> WB_LD; sw mem_write=1 -> IF.
- WB_LD: reg_write=1, wb_src=01, reg_dst=00 -> IF.
- HALT: all enables 0, halted=1; exits only via reset.
- ext_sel=0 for andi/ori/xori, 1 otherwise (valid from ID).
- Outputs not listed for a state are 0.

## Timing
- Outputs are pure functions of state and opcode; state updates on rising `clk`.
- Reset: state=IF immediately (async), so outputs are IF values: ir_write=1, pc_write=1, alu_src_b=01, all other outputs 0, instret=0.
- Cycles per instruction: j/jr/jal/NOP 2; branch 3 (taken or not); ALU 4; sw 4; lw 5.
- `zero`/`sign` sampled combinationally in EXE_BR only; ignored elsewhere.
- Reset mid-instruction abandons it; no partial write beyond the current cycle's strobes.

## Configuration
- `CTRL_INSTRET_EN` defined: `instret` port present; increments by 1 on every transition into IF from any state except reset (NOPs count, HALT does not); wraps 0xFFFFFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset released, opcode=000000 -> states IF,ID,EXE_AL,WB_AL,IF; WB_AL has reg_write=1, reg_dst=01, aluop=2 in EXE_AL.
- lw (110001) -> 5 cycles; mem_read=1 in MEM, reg_write=1 wb_src=01 in WB_LD; sw (110000) -> 4 cycles, mem_write=1, reg_write never 1.
- beq with zero=1 -> pc_write=1 pc_src=01 in EXE_BR; zero=0 -> pc_write=0; bltz with sign=1 -> pc_write=1.
- jal (111010) -> 2 cycles; ID asserts pc_write, reg_write, reg_dst=10, wb_src=10.
- halt (111111) -> HALT held 20 cycles, halted=1, no enables; rst_n low mid-EXE_LS -> IF outputs immediately.
- With CTRL_INSTRET_EN: 3 add + 1 lw + 1 undefined opcode -> instret=5; preload 0xFFFFFFFF -> next retire gives 0.

Source files
------------

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle Moore control unit sequencing IF/ID/EXE/MEM/WB and driving datapath controls.
// Optional retired-instruction counter on o_instret when CTRL_INSTRET_EN is defined.
module mc_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_sign,
    output logic       o_pc_write,
    output logic       o_ir_write,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_reg_write,
    output logic [1:0] o_aluop,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic       o_ext_sel,
    output logic [1:0] o_pc_src,
    output logic [1:0] o_reg_dst,
    output logic [1:0] o_wb_src,
    output logic       o_halted
`ifdef CTRL_INSTRET_EN
    ,
    output logic [31:0] o_instret
`endif
);
    typedef enum logic [3:0] {
        S_IF, S_ID, S_EXE_AL, S_WB_AL, S_EXE_BR, S_EXE_LS, S_MEM, S_WB_LD, S_HALT
    } state_t;

    state_t r_state, w_next;

    logic w_add, w_sub, w_addiu, w_and, w_andi, w_ori, w_xori, w_sll, w_slti, w_slt;
    logic w_sw, w_lw, w_beq, w_bne, w_bltz, w_j, w_jr, w_jal, w_halt;
    logic w_alu_reg, w_alu_imm, w_log_imm;

    assign w_add   = i_opcode == 6'b000000;
    assign w_sub   = i_opcode == 6'b000001;
    assign w_addiu = i_opcode == 6'b000010;
    assign w_and   = i_opcode == 6'b010000;
    assign w_andi  = i_opcode == 6'b010001;
    assign w_ori   = i_opcode == 6'b010010;
    assign w_xori  = i_opcode == 6'b010011;
    assign w_sll   = i_opcode == 6'b011000;
    assign w_slti  = i_opcode == 6'b100110;
    assign w_slt   = i_opcode == 6'b100111;
    assign w_sw    = i_opcode == 6'b110000;
    assign w_lw    = i_opcode == 6'b110001;
    assign w_beq   = i_opcode == 6'b110100;
    assign w_bne   = i_opcode == 6'b110101;
    assign w_bltz  = i_opcode == 6'b110110;
    assign w_j     = i_opcode == 6'b111000;
    assign w_jr    = i_opcode == 6'b111001;
    assign w_jal   = i_opcode == 6'b111010;
    assign w_halt  = i_opcode == 6'b111111;

    assign w_alu_reg = w_add | w_sub | w_and | w_sll | w_slt;
    assign w_alu_imm = w_addiu | w_andi | w_ori | w_xori | w_slti;
    assign w_log_imm = w_andi | w_ori | w_xori;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IF;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_pc_write  = 1'b0;
        o_ir_write  = 1'b0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        o_reg_write = 1'b0;
        o_aluop     = 2'b00;
        o_alu_src_a = 2'b00;
        o_alu_src_b = 2'b00;
        o_pc_src    = 2'b00;
        o_reg_dst   = 2'b00;
        o_wb_src    = 2'b00;
        o_halted    = 1'b0;
        // IR holds the fetched opcode only after IF, so the extension select is meaningful from ID on
        o_ext_sel   = (r_state != S_IF) && !w_log_imm;
        case (r_state)
            S_IF: begin
                o_ir_write  = 1'b1;
                o_pc_write  = 1'b1;
                o_alu_src_b = 2'b01;
                w_next      = S_ID;
            end
            S_ID: begin
                if (w_alu_reg | w_alu_imm)      w_next = S_EXE_AL;
                else if (w_beq | w_bne | w_bltz) w_next = S_EXE_BR;
                else if (w_lw | w_sw)           w_next = S_EXE_LS;
                else if (w_halt)                w_next = S_HALT;
                else begin
                    w_next      = S_IF;
                    o_pc_write  = w_j | w_jr | w_jal;
                    o_pc_src    = w_jr ? 2'b11 : (w_j | w_jal) ? 2'b10 : 2'b00;
                    o_reg_write = w_jal;
                    o_reg_dst   = w_jal ? 2'b10 : 2'b00;
                    o_wb_src    = w_jal ? 2'b10 : 2'b00;
                end
            end
            S_EXE_AL: begin
                o_aluop     = 2'b10;
                o_alu_src_a = w_sll ? 2'b10 : 2'b01;
                o_alu_src_b = w_alu_imm ? 2'b10 : 2'b00;
                w_next      = S_WB_AL;
            end
            S_WB_AL: begin
                o_reg_write = 1'b1;
                o_reg_dst   = w_alu_imm ? 2'b00 : 2'b01;
                w_next      = S_IF;
            end
            S_EXE_BR: begin
                o_aluop     = 2'b01;
                o_alu_src_a = 2'b01;
                o_alu_src_b = w_bltz ? 2'b11 : 2'b00;
                o_pc_src    = 2'b01;
                o_pc_write  = (w_beq & i_zero) | (w_bne & ~i_zero) | (w_bltz & i_sign);
                w_next      = S_IF;
            end
            S_EXE_LS: begin
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b10;
                w_next      = S_MEM;
            end
            S_MEM: begin
                o_mem_read  = w_lw;
                o_mem_write = w_sw;
                w_next      = w_lw ? S_WB_LD : S_IF;
            end
            S_WB_LD: begin
                o_reg_write = 1'b1;
                o_wb_src    = 2'b01;
                w_next      = S_IF;
            end
            S_HALT: begin
                o_halted = 1'b1;
                w_next   = S_HALT;
            end
            default: w_next = S_IF;
        endcase
    end

`ifdef CTRL_INSTRET_EN
    logic [31:0] r_instret;
    logic        w_retire;

    // IF never loops to itself, so any step into IF is a retirement
    assign w_retire  = (w_next == S_IF) && (r_state != S_IF);
    assign o_instret = r_instret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_instret <= 32'd0;
        else if (w_retire) r_instret <= r_instret + 32'd1;
    end
`endif
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed checks of per-state outputs and cycle counts of mc_control_fsm.
// Instret checks are compiled only when CTRL_INSTRET_EN is defined.
module tb_mc_control_fsm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       sign = 1'b0;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, ext_sel, halted;
    logic [1:0] aluop, alu_src_a, alu_src_b, pc_src, reg_dst, wb_src;
`ifdef CTRL_INSTRET_EN
    logic [31:0] instret;
`endif
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .i_opcode(opcode), .i_zero(zero), .i_sign(sign),
        .o_pc_write(pc_write), .o_ir_write(ir_write), .o_mem_read(mem_read),
        .o_mem_write(mem_write), .o_reg_write(reg_write), .o_aluop(aluop),
        .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_ext_sel(ext_sel),
        .o_pc_src(pc_src), .o_reg_dst(reg_dst), .o_wb_src(wb_src), .o_halted(halted)
`ifdef CTRL_INSTRET_EN
        , .o_instret(instret)
`endif
    );

    // {pcw, irw, mr, mw, rw, aluop, src_a, src_b, ext, pc_src, reg_dst, wb_src, halted}
    logic [18:0] w_out;
    assign w_out = {pc_write, ir_write, mem_read, mem_write, reg_write, aluop, alu_src_a,
                    alu_src_b, ext_sel, pc_src, reg_dst, wb_src, halted};

    function automatic logic [18:0] ex(input logic pcw, irw, mr, mw, rw, input logic [1:0] op,
                                       sa, sb, input logic ext, input logic [1:0] ps, rd, wb,
                                       input logic h);
        return {pcw, irw, mr, mw, rw, op, sa, sb, ext, ps, rd, wb, h};
    endfunction

    localparam logic [18:0] V_IF = 19'b1_1_0_0_0_00_00_01_0_00_00_00_0;
    localparam logic [18:0] V_ID = 19'b0_0_0_0_0_00_00_00_1_00_00_00_0;

    // Runs one instruction from IF; e lists expected outputs for each cycle and ends with the next IF.
    task automatic test_instr(input string nm, input logic [5:0] op, input logic z, input logic s,
                              input logic [18:0] e[$]);
        opcode = op; zero = z; sign = s;
        foreach (e[i]) begin
            if (i > 0) @(negedge clk);
            tests++;
            if (w_out !== e[i]) begin
                fails++;
                $display("FAIL %s cyc%0d: got %b want %b", nm, i, w_out, e[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; opcode = 6'b110001;
        #1;
        tests++;
        if (w_out !== V_IF) begin fails++; $display("FAIL reset: got %b want %b", w_out, V_IF); end
`ifdef CTRL_INSTRET_EN
        tests++;
        if (instret !== 32'd0) begin fails++; $display("FAIL reset_instret: got %h want 0", instret); end
`endif
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_alu();
        test_instr("add", 6'b000000, 0, 0, '{V_IF, V_ID,
            ex(0,0,0,0,0,2'b10,2'b01,2'b00,1,0,0,0,0),
            ex(0,0,0,0,1,0,0,0,1,0,2'b01,0,0), V_IF});
        test_instr("sll", 6'b011000, 0, 0, '{V_IF, V_ID,
            ex(0,0,0,0,0,2'b10,2'b10,2'b00,1,0,0,0,0),
            ex(0,0,0,0,1,0,0,0,1,0,2'b01,0,0), V_IF});
        test_instr("ori", 6'b010010, 0, 0, '{V_IF, 19'd0,
            ex(0,0,0,0,0,2'b10,2'b01,2'b10,0,0,0,0,0),
            ex(0,0,0,0,1,0,0,0,0,0,2'b00,0,0), V_IF});
        test_instr("slti", 6'b100110, 1, 1, '{V_IF, V_ID,
            ex(0,0,0,0,0,2'b10,2'b01,2'b10,1,0,0,0,0),
            ex(0,0,0,0,1,0,0,0,1,0,2'b00,0,0), V_IF});
    endtask

    task automatic test_load_store();
        test_instr("lw", 6'b110001, 0, 0, '{V_IF, V_ID,
            ex(0,0,0,0,0,0,2'b01,2'b10,1,0,0,0,0),
            ex(0,0,1,0,0,0,0,0,1,0,0,0,0),
            ex(0,0,0,0,1,0,0,0,1,0,2'b00,2'b01,0), V_IF});
        test_instr("sw", 6'b110000, 0, 0, '{V_IF, V_ID,
            ex(0,0,0,0,0,0,2'b01,2'b10,1,0,0,0,0),
            ex(0,0,0,1,0,0,0,0,1,0,0,0,0), V_IF});
    endtask

    task automatic test_branch();
        test_instr("beq_taken", 6'b110100, 1, 0, '{V_IF, V_ID,
            ex(1,0,0,0,0,2'b01,2'b01,2'b00,1,2'b01,0,0,0), V_IF});
        test_instr("beq_not", 6'b110100, 0, 1, '{V_IF, V_ID,
            ex(0,0,0,0,0,2'b01,2'b01,2'b00,1,2'b01,0,0,0), V_IF});
        test_instr("bne_taken", 6'b110101, 0, 0, '{V_IF, V_ID,
            ex(1,0,0,0,0,2'b01,2'b01,2'b00,1,2'b01,0,0,0), V_IF});
        test_instr("bltz_taken", 6'b110110, 0, 1, '{V_IF, V_ID,
            ex(1,0,0,0,0,2'b01,2'b01,2'b11,1,2'b01,0,0,0), V_IF});
        test_instr("bltz_not", 6'b110110, 1, 0, '{V_IF, V_ID,
            ex(0,0,0,0,0,2'b01,2'b01,2'b11,1,2'b01,0,0,0), V_IF});
    endtask

    task automatic test_jumps();
        test_instr("jal", 6'b111010, 0, 0, '{V_IF,
            ex(1,0,0,0,1,0,0,0,1,2'b10,2'b10,2'b10,0), V_IF});
        test_instr("j", 6'b111000, 0, 0, '{V_IF, ex(1,0,0,0,0,0,0,0,1,2'b10,0,0,0), V_IF});
        test_instr("jr", 6'b111001, 0, 0, '{V_IF, ex(1,0,0,0,0,0,0,0,1,2'b11,0,0,0), V_IF});
        test_instr("nop", 6'b000111, 1, 1, '{V_IF, V_ID, V_IF});
    endtask

    task automatic test_halt();
        logic [18:0] v_h = ex(0,0,0,0,0,0,0,0,1,0,0,0,1);
        test_instr("halt", 6'b111111, 1, 1, '{V_IF, V_ID, v_h});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++;
            if (w_out !== v_h) begin fails++; $display("FAIL halt_hold%0d: got %b want %b", i, w_out, v_h); end
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0; #1; @(negedge clk); rst_n = 1'b1;
        test_instr("lw_pre", 6'b110001, 0, 0, '{V_IF, V_ID,
            ex(0,0,0,0,0,0,2'b01,2'b10,1,0,0,0,0)});
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (w_out !== V_IF) begin fails++; $display("FAIL reset_mid: got %b want %b", w_out, V_IF); end
        @(negedge clk); rst_n = 1'b1;
        test_instr("post_reset_add", 6'b000000, 0, 0, '{V_IF, V_ID,
            ex(0,0,0,0,0,2'b10,2'b01,2'b00,1,0,0,0,0)});
        rst_n = 1'b0; #1; @(negedge clk); rst_n = 1'b1;
    endtask

`ifdef CTRL_INSTRET_EN
    task automatic test_instret();
        for (int i = 0; i < 3; i++) test_instr("ir_add", 6'b000000, 0, 0, '{V_IF, V_ID,
            ex(0,0,0,0,0,2'b10,2'b01,2'b00,1,0,0,0,0),
            ex(0,0,0,0,1,0,0,0,1,0,2'b01,0,0), V_IF});
        test_instr("ir_lw", 6'b110001, 0, 0, '{V_IF, V_ID,
            ex(0,0,0,0,0,0,2'b01,2'b10,1,0,0,0,0),
            ex(0,0,1,0,0,0,0,0,1,0,0,0,0),
            ex(0,0,0,0,1,0,0,0,1,0,2'b00,2'b01,0), V_IF});
        test_instr("ir_nop", 6'b101010, 0, 0, '{V_IF, V_ID, V_IF});
        tests++;
        if (instret !== 32'd5) begin fails++; $display("FAIL instret_count: got %0d want 5", instret); end
        force dut.r_instret = 32'hFFFF_FFFF;
        #1 release dut.r_instret;
        test_instr("ir_wrap_jal", 6'b111010, 0, 0, '{V_IF,
            ex(1,0,0,0,1,0,0,0,1,2'b10,2'b10,2'b10,0), V_IF});
        tests++;
        if (instret !== 32'd0) begin fails++; $display("FAIL instret_wrap: got %h want 0", instret); end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_jumps();
        test_halt();
        test_reset_mid();
`ifdef CTRL_INSTRET_EN
        test_instret();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
